// File: rtl/piano_note_arbiter_pkg.sv
// piano_note_arbiter_pkg: key codes and arbiter state encoding shared by the piano display blocks
package piano_note_arbiter_pkg;
  typedef enum logic [3:0] {
    KEY_C, KEY_CS, KEY_D, KEY_DS, KEY_E, KEY_F,
    KEY_FS, KEY_G, KEY_GS, KEY_A, KEY_AS, KEY_B
  } key_e;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_e;
endpackage

// File: rtl/piano_note_arbiter_frame_tick.sv
// frame_tick_detect: registers active-low vsync and pulses frame_o for one cycle on its falling edge
module frame_tick_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic frame_o
);
  logic prev_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) prev_q <= 1'b1;
    else prev_q <= vsync_i;
  assign frame_o = prev_q & ~vsync_i;
endmodule

// File: rtl/piano_note_arbiter.sv
// piano_note_arbiter: round-robin grant of the key highlight between keypad and sequencer, held for whole frames
module piano_note_arbiter
  import piano_note_arbiter_pkg::*;
#(
  parameter int NUM_KEYS    = 12,
  parameter int HOLD_FRAMES = 8,
  parameter int KEY_W       = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                vsync_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  input  logic                seq_valid_i,
  input  logic [KEY_W-1:0]    seq_key_i,
  output logic                seq_ready_o,
  output logic                hl_valid_o,
  output logic [KEY_W-1:0]    hl_key_o,
  output logic [NUM_KEYS-1:0] key_mask_o,
  output logic                owner_o
);
  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_FRAMES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, owner_q, owner_d, last_q, last_d;
  logic [KEY_W-1:0] key_q, key_d, man_key, win_key;
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic frame, man_req, any_req, pick_seq, win_valid, idle_eval;
  frame_tick_detect u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .vsync_i(vsync_i),
    .frame_o(frame)
  );
  always_comb begin
    man_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) man_key = keys_i[i] ? KEY_W'(i) : man_key;
  end
  assign man_req   = |keys_i;
  assign any_req   = man_req | seq_valid_i;
  // last_q = 1 means the sequencer won last time, so the keypad wins a tie
  assign pick_seq  = seq_valid_i & (~man_req | ~last_q);
  assign win_key   = pick_seq ? seq_key_i : man_key;
  assign win_valid = {1'b0, win_key} < (KEY_W + 1)'(NUM_KEYS);
  // the final hold frame is also the next decision frame, so grants run back to back
  assign idle_eval = frame & (state_q == S_IDLE | (state_q == S_HOLD & cnt_q == '0));
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    key_d       = key_q;
    mask_d      = mask_q;
    owner_d     = owner_q;
    last_d      = last_q;
    seq_ready_o = 1'b0;
    if (idle_eval) begin
      state_d = any_req ? S_GRANT : S_IDLE;
      valid_d = any_req & valid_q;
      key_d   = any_req ? key_q : '0;
      mask_d  = any_req ? mask_q : '0;
    end else if (state_q == S_HOLD && frame) begin
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == S_GRANT) begin
      state_d     = any_req ? S_HOLD : S_IDLE;
      cnt_d       = any_req ? CNT_LOAD : cnt_q;
      valid_d     = any_req & win_valid;
      key_d       = any_req & win_valid ? win_key : '0;
      mask_d      = any_req & win_valid ? NUM_KEYS'(1) << win_key : '0;
      owner_d     = any_req ? pick_seq : owner_q;
      last_d      = any_req ? pick_seq : last_q;
      seq_ready_o = any_req & pick_seq;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      key_q   <= '0;
      mask_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  assign hl_valid_o = valid_q;
  assign hl_key_o   = key_q;
  assign key_mask_o = mask_q;
  assign owner_o    = owner_q;
endmodule
